seq_multiplier: RTL and testbench

- Parametrised multi-cycle shift-and-add multiplier for the CPU's MULT/MULTU path.
- Replaces a wide combinational adder array with one WIDTH-bit adder, iterated over WIDTH cycles.
- Supports signed and unsigned operands through a mode input.
- Uses a start/busy/done handshake toward the control unit and holds the 2*WIDTH-bit product until the next operation.

---
 rtl/seq_multiplier.sv | 112 +++++++++++
 tb/tb_seq_multiplier.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-and-add multiplier, one WIDTH+1-bit adder.
// Ports: clk, reset, start, is_signed, a, b in; busy, done, product out.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   acc_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] prod_q;

  logic [WIDTH:0]     sum_d;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   mplier_d;
  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic               neg_d;
  logic [2*WIDTH-1:0] raw_d;
  logic [2*WIDTH-1:0] res_d;
  logic               last_d;

  always_comb begin
    // The carry out of the add becomes the new MSB after the shift.
    sum_d    = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d    = sum_d[WIDTH:1];
    mplier_d = {sum_d[0], mplier_q[WIDTH-1:1]};
    raw_d    = {acc_d, mplier_d};
    res_d    = neg_q ? -raw_d : raw_d;
    last_d   = (cnt_q == CW'(WIDTH - 1));
    // Magnitude of the most negative value is still exact unsigned.
    a_mag_d  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag_d  = (is_signed && b[WIDTH-1]) ? -b : b;
    neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a_mag_d;
            mplier_q <= b_mag_d;
            acc_q    <= '0;
            neg_q    <= neg_d;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_d) begin
            prod_q  <= res_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of seq_multiplier at WIDTH 32,
// plus a WIDTH 4/8/16 sweep against an arithmetic reference.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  logic        start_s;
  logic        sgn_s;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy4, done4, busy8, done8, busy16, done16;
  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic [31:0] prod16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start_s), .is_signed(sgn_s),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start_s), .is_signed(sgn_s),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  seq_multiplier #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start_s), .is_signed(sgn_s),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .product(prod16)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic s, input int w);
    longint sx, sy, p, m;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    p = sx * sy;
    m = (longint'(1) << (2 * w)) - 1;
    return 64'(p & m);
  endfunction

  // One WIDTH-32 operation: start pulse, busy length, done pulse, result.
  task automatic exec32(input logic [31:0] ia, input logic [31:0] ib,
                        input logic is, input logic [63:0] exp,
                        input string tag);
    int n;
    logic [63:0] held;
    bit stable;
    @(negedge clk);
    a = ia; b = ib; is_signed = is; start = 1'b1;
    held = product;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    stable = 1'b1;
    while (busy && n < 40) begin
      n++;
      if (product !== held) stable = 1'b0;
      a = $urandom; b = $urandom; is_signed = 1'($urandom);
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 64'(n), 64'd32);
    chk({tag, " no partial"}, 64'(stable), 64'd1);
    chk({tag, " done/busy"}, {62'd0, done, busy}, 64'b10);
    chk({tag, " product"}, product, exp);
    @(negedge clk);
    chk({tag, " done pulse"}, {62'd0, done, busy}, 64'b00);
    chk({tag, " hold"}, product, exp);
  endtask

  initial begin
    int n;
    int l4, l8, l16;
    bit stable, seen;
    logic [63:0] p4, p8, p16;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    start_s = 1'b0; sgn_s = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle after reset", {busy, done, product}, 66'd0);
    end

    exec32(32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0000_0000_0626_0060,
           "ubasic");
    exec32(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "m3x7");
    exec32(32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b1, 64'h15, "m3xm7");
    exec32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000,
           "minxmin");
    exec32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001,
           "umax");
    exec32(32'd0, 32'hFFFF_FFFB, 1'b1, 64'd0, "zero signed");
    exec32(32'hFFFF_FFFF, 32'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, "umax x1");

    // start held high; operands scrambled while busy.
    @(negedge clk);
    a = 32'd5; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin
      n++;
      a = $urandom; b = $urandom; is_signed = 1'($urandom);
      @(negedge clk);
    end
    chk("hs busy cycles", 64'(n), 64'd32);
    chk("hs done", {62'd0, done, busy}, 64'b10);
    chk("hs product", product, 64'd35);
    a = $urandom; b = $urandom;
    @(negedge clk);
    chk("hs idle gap", {62'd0, done, busy}, 64'b00);
    a = 32'd9; b = 32'd11; is_signed = 1'b0;
    @(negedge clk);
    chk("hs accepted", {62'd0, done, busy}, 64'b01);
    n = 0;
    stable = 1'b1;
    while (busy && n < 40) begin
      n++;
      if (product !== 64'd35) stable = 1'b0;
      a = $urandom; b = $urandom; is_signed = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("hs2 busy cycles", 64'(n), 64'd32);
    chk("hs stable", 64'(stable), 64'd1);
    chk("hs2 done", {62'd0, done, busy}, 64'b10);
    chk("hs2 product", product, 64'd99);

    // Abort an operation mid-run.
    @(negedge clk);
    a = 32'h0000_1234; b = 32'h0000_5678; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort reset", {busy, done, product}, 66'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy || product !== 64'd0) seen = 1'b1;
    end
    chk("abort quiet", 64'(seen), 64'd0);
    exec32(32'd5, 32'd6, 1'b0, 64'd30, "after abort");

    // Small widths in parallel: exhaustive W4, random W8/W16.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      a4 = i[3:0]; b4 = i[7:4]; sgn_s = i[8];
      a8 = 8'($urandom); b8 = 8'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      l4 = 0; l8 = 0; l16 = 0;
      p4 = '0; p8 = '0; p16 = '0;
      for (int k = 1; k <= 20; k++) begin
        if (done4)  begin l4 = k;  p4 = 64'(prod4);  end
        if (done8)  begin l8 = k;  p8 = 64'(prod8);  end
        if (done16) begin l16 = k; p16 = 64'(prod16); end
        @(negedge clk);
      end
      chk("w4 lat", 64'(l4), 64'd5);
      chk("w4 prod", p4, ref_mul(16'(a4), 16'(b4), sgn_s, 4));
      chk("w8 lat", 64'(l8), 64'd9);
      chk("w8 prod", p8, ref_mul(16'(a8), 16'(b8), sgn_s, 8));
      chk("w16 lat", 64'(l16), 64'd17);
      chk("w16 prod", p16, ref_mul(a16, b16, sgn_s, 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
